commit_controller: RTL

COMMIT_CONTROLLER -- requirements
Module: commit_controller

---
 rtl/commit_controller_if.sv | 50 +++++
 rtl/commit_controller.sv | 133 +++++++++++++
 2 files changed

// File: rtl/commit_controller_if.sv
// Commit-stage bus: graduation list view, exception/CSR/store side-band
// signals and the commit decisions returned by the controller.
interface commit_controller_if #(
   parameter int NUM_ENTRIES = 32
);
   localparam int IDX = $clog2(NUM_ENTRIES);

   // Graduation list and side-band inputs to the controller
   logic [1:0]     gl_valid_i;
   logic [1:0]     gl_is_store_i;
   logic [1:0]     gl_is_csr_i;
   logic [1:0]     gl_ex_valid_i;
   logic [IDX-1:0] gl_head_i;
   logic           exception_valid_i;
   logic [IDX-1:0] exception_index_i;
   logic           store_ready_i;
   logic           csr_ack_i;
   logic           csr_ex_i;

   // Commit decisions produced by the controller
   logic [1:0]     read_head_o;
   logic [1:0]     store_commit_o;
   logic           csr_req_o;
   logic           flush_commit_o;
   logic           trap_o;
   logic [IDX-1:0] trap_index_o;
   logic [63:0]    retired_count_o;
   logic [1:0]     state_dbg_o;

   // Handshakes: a graduation list slot is offered while gl_valid_i[k] is
   // high and is consumed exactly in the cycle read_head_o[k] is high; a
   // store is taken by the store buffer in a cycle where store_ready_i and
   // store_commit_o[k] are both high; csr_req_o is held high until and
   // including the cycle csr_ack_i is returned.
   modport slave (
      input  gl_valid_i, gl_is_store_i, gl_is_csr_i, gl_ex_valid_i, gl_head_i,
      input  exception_valid_i, exception_index_i, store_ready_i,
      input  csr_ack_i, csr_ex_i,
      output read_head_o, store_commit_o, csr_req_o, flush_commit_o,
      output trap_o, trap_index_o, retired_count_o, state_dbg_o
   );

   modport master (
      output gl_valid_i, gl_is_store_i, gl_is_csr_i, gl_ex_valid_i, gl_head_i,
      output exception_valid_i, exception_index_i, store_ready_i,
      output csr_ack_i, csr_ex_i,
      input  read_head_o, store_commit_o, csr_req_o, flush_commit_o,
      input  trap_o, trap_index_o, retired_count_o, state_dbg_o
   );
endinterface

// File: rtl/commit_controller.sv
// Two-wide in-order commit controller: retires up to two finished
// instructions per cycle from the graduation list head, serialises CSR
// instructions through the CSR unit, limits store release to one per cycle
// and turns an exception at the head into a flush plus trap.
module commit_controller #(
   parameter int NUM_ENTRIES = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   commit_controller_if.slave    bus
);
   localparam int IDX = $clog2(NUM_ENTRIES);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_CSR_WAIT = 2'd1,
      S_FLUSH    = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [63:0]    count_q, count_d;

   logic [IDX-1:0] head_p1;
   logic           head_ex;
   logic           slot1_ex;
   logic           slot0_ok;
   logic           slot1_ok;

   logic [1:0]     read_head;
   logic           csr_req;
   logic           flush_commit;
   logic           trap;
   logic [IDX-1:0] trap_index;

   // Index of the second slot; wraps by truncation to IDX bits
   assign head_p1 = bus.gl_head_i + IDX'(1);

   // Exception visible at the head entry (list-wide pointer or per-slot flag)
   assign head_ex = bus.gl_valid_i[0] &
                    ((bus.exception_valid_i & (bus.exception_index_i == bus.gl_head_i)) |
                     bus.gl_ex_valid_i[0]);

   // Exception pending on the second slot blocks it from pairing
   assign slot1_ex = bus.gl_ex_valid_i[1] |
                     (bus.exception_valid_i & (bus.exception_index_i == head_p1));

   // Head can retire unless it is a store the store buffer cannot take
   assign slot0_ok = bus.gl_valid_i[0] &
                     (~bus.gl_is_store_i[0] | bus.store_ready_i);

   // Second slot pairs only with a retiring head, never a CSR, never a second
   // store in the same cycle, and a lone store still needs the buffer ready
   assign slot1_ok = slot0_ok & bus.gl_valid_i[1] & ~bus.gl_is_csr_i[1] & ~slot1_ex &
                     ~(bus.gl_is_store_i[0] & bus.gl_is_store_i[1]) &
                     (~bus.gl_is_store_i[1] | bus.store_ready_i);

   // Commit decisions and next state, all combinational from state and inputs
   always_comb begin
      read_head    = 2'b00;
      csr_req      = 1'b0;
      flush_commit = 1'b0;
      trap         = 1'b0;
      trap_index   = '0;
      state_d      = state_q;
      case (state_q)
         S_RUN: begin
            if (head_ex) begin
               flush_commit = 1'b1;
               trap         = 1'b1;
               trap_index   = bus.gl_head_i;
               state_d      = S_FLUSH;
            end else if (bus.gl_valid_i[0] & bus.gl_is_csr_i[0]) begin
               csr_req = 1'b1;
               state_d = S_CSR_WAIT;
            end else if (slot0_ok) begin
               read_head = slot1_ok ? 2'b11 : 2'b01;
            end
         end
         S_CSR_WAIT: begin
            csr_req = 1'b1;
            if (bus.csr_ack_i) begin
               if (bus.csr_ex_i) begin
                  flush_commit = 1'b1;
                  trap         = 1'b1;
                  trap_index   = bus.gl_head_i;
                  state_d      = S_FLUSH;
               end else begin
                  read_head = 2'b01;
                  state_d   = S_RUN;
               end
            end
         end
         S_FLUSH: begin
            state_d = S_RUN;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
      // Nothing leaves the controller while reset is held
      if (rst_i) begin
         read_head    = 2'b00;
         csr_req      = 1'b0;
         flush_commit = 1'b0;
         trap         = 1'b0;
         trap_index   = '0;
         state_d      = S_RUN;
      end
   end

   // Retired counter advances by the number of entries popped this cycle
   assign count_d = count_q + {63'd0, read_head[0]} + {63'd0, read_head[1]};

   // State and retired counter registers; reset aborts any CSR wait or flush
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_RUN;
         count_q <= 64'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign bus.read_head_o     = read_head;
   assign bus.store_commit_o  = read_head & bus.gl_is_store_i;
   assign bus.csr_req_o       = csr_req;
   assign bus.flush_commit_o  = flush_commit;
   assign bus.trap_o          = trap;
   assign bus.trap_index_o    = trap_index;
   assign bus.retired_count_o = count_q;
   assign bus.state_dbg_o     = state_q;
endmodule
